// File: rtl/aurora_tx_data_unpack.sv
// Aurora TX unpacker: fetches 512-bit DDR words one request at a time
// and streams them as 64-bit beats, lane [63:0] first.
module aurora_tx_data_unpack #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64,
    parameter int LEN_W     = 16
) (
    input  logic                 aurora_log_clk_0,
    input  logic                 aurora_rst_0,
    input  logic                 xdma_vin_mem_clear_i,
    input  logic                 tx_start_i,
    input  logic [LEN_W-1:0]     tx_frame_len_i,
    output logic                 ddr_rd_req_o,
    input  logic                 ddr_rd_valid_i,
    input  logic [IN_WIDTH-1:0]  ddr_rd_data_i,
    output logic                 aurora_tx_tvalid_o,
    input  logic                 aurora_tx_tready_i,
    output logic [OUT_WIDTH-1:0] aurora_tx_tdata_o,
    output logic                 aurora_tx_tlast_o,
    output logic                 tx_busy_o,
    output logic [31:0]          tx_beat_cnt_o,
    output logic [31:0]          tx_stall_cnt_o
);

    localparam int LANES = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = $clog2(LANES);
    localparam int BL_W  = LEN_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    req_left;
    logic [BL_W-1:0]     beat_left;
    logic [IDX_W-1:0]    beat_idx;
    logic                req_prev;
    logic [1:0]          outst;
    logic [1:0]          drop_cnt;
    logic                act_valid;
    logic                pre_valid;
    logic [IN_WIDTH-1:0] act_data;
    logic [IN_WIDTH-1:0] pre_data;
    logic                started;
    logic [31:0]         beat_cnt;
    logic [31:0]         stall_cnt;

    logic       req_fire;
    logic       rsp_take;
    logic       rsp_drop;
    logic       pop;
    logic       pop_word;
    logic       last_beat;
    logic [2:0] occ_sum;
    logic [1:0] pend_nxt;

    // Responses still owed from before a clear count against the window too,
    // so at most two DDR words are ever in flight or buffered.
    assign occ_sum = {1'b0, outst} + {1'b0, drop_cnt}
                   + {2'b0, act_valid} + {2'b0, pre_valid};

    assign req_fire = (state == RUN) && (req_left != '0)
                   && (occ_sum < 3'd2) && !req_prev;

    assign rsp_drop  = ddr_rd_valid_i && (drop_cnt != 2'd0);
    assign rsp_take  = ddr_rd_valid_i && (drop_cnt == 2'd0) && (outst != 2'd0);
    assign pop       = act_valid && aurora_tx_tready_i;
    assign pop_word  = pop && (beat_idx == LAST_IDX);
    assign last_beat = act_valid && (beat_left == BL_W'(1));

    assign pend_nxt = outst + drop_cnt + {1'b0, req_fire}
                    - {1'b0, rsp_take | rsp_drop};

    always_ff @(posedge aurora_log_clk_0) begin
        if (aurora_rst_0 || xdma_vin_mem_clear_i) begin
            state     <= IDLE;
            req_left  <= '0;
            beat_left <= '0;
            beat_idx  <= '0;
            req_prev  <= 1'b0;
            outst     <= 2'd0;
            // A clear leaves DDR responses in flight; remember how many to discard.
            drop_cnt  <= aurora_rst_0 ? 2'd0 : pend_nxt;
            act_valid <= 1'b0;
            pre_valid <= 1'b0;
            act_data  <= '0;
            pre_data  <= '0;
            started   <= 1'b0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            req_prev <= req_fire;
            if (req_fire) begin
                req_left <= req_left - 1'b1;
            end
            outst <= outst + {1'b0, req_fire} - {1'b0, rsp_take};
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 2'd1;
            end

            if (pop) begin
                beat_cnt  <= beat_cnt + 32'd1;
                beat_left <= beat_left - 1'b1;
                beat_idx  <= beat_idx + 1'b1;
                started   <= 1'b1;
            end
            if ((state == RUN) && !act_valid && started) begin
                stall_cnt <= stall_cnt + 32'd1;
            end

            if (pop_word) begin
                if (pre_valid) begin
                    act_data  <= pre_data;
                    act_valid <= 1'b1;
                    pre_valid <= rsp_take;
                    if (rsp_take) begin
                        pre_data <= ddr_rd_data_i;
                    end
                end else if (rsp_take) begin
                    act_data  <= ddr_rd_data_i;
                    act_valid <= 1'b1;
                end else begin
                    act_valid <= 1'b0;
                end
            end else begin
                if (pop) begin
                    act_data <= act_data >> OUT_WIDTH;
                end
                if (rsp_take) begin
                    if (!act_valid) begin
                        act_data  <= ddr_rd_data_i;
                        act_valid <= 1'b1;
                    end else begin
                        pre_data  <= ddr_rd_data_i;
                        pre_valid <= 1'b1;
                    end
                end
            end

            unique case (state)
                IDLE: begin
                    if (tx_start_i && (tx_frame_len_i != '0)) begin
                        state     <= RUN;
                        req_left  <= tx_frame_len_i;
                        beat_left <= {tx_frame_len_i, {IDX_W{1'b0}}};
                        beat_idx  <= '0;
                        started   <= 1'b0;
                    end
                end
                RUN: begin
                    if (pop && last_beat) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ddr_rd_req_o       = req_fire;
    assign aurora_tx_tvalid_o = act_valid;
    assign aurora_tx_tdata_o  = act_data[OUT_WIDTH-1:0];
    assign aurora_tx_tlast_o  = last_beat;
    assign tx_busy_o          = (state != IDLE);
    assign tx_beat_cnt_o      = beat_cnt;
    assign tx_stall_cnt_o     = stall_cnt;

endmodule

// File: tb/tb_aurora_tx_data_unpack.sv
// Bench for aurora_tx_data_unpack: DDR responder model, beat scoreboard
// and per-cycle protocol checks against a queue-based frame model.
module tb_aurora_tx_data_unpack;

    localparam int IW = 512;
    localparam int OW = 64;
    localparam int LW = 16;

    logic          aurora_log_clk_0 = 1'b0;
    logic          aurora_rst_0;
    logic          xdma_vin_mem_clear_i;
    logic          tx_start_i;
    logic [LW-1:0] tx_frame_len_i;
    logic          ddr_rd_req_o;
    logic          ddr_rd_valid_i;
    logic [IW-1:0] ddr_rd_data_i;
    logic          aurora_tx_tvalid_o;
    logic          aurora_tx_tready_i;
    logic [OW-1:0] aurora_tx_tdata_o;
    logic          aurora_tx_tlast_o;
    logic          tx_busy_o;
    logic [31:0]   tx_beat_cnt_o;
    logic [31:0]   tx_stall_cnt_o;

    always #5 aurora_log_clk_0 = ~aurora_log_clk_0;

    aurora_tx_data_unpack #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .LEN_W    (LW)
    ) dut (
        .aurora_log_clk_0    (aurora_log_clk_0),
        .aurora_rst_0        (aurora_rst_0),
        .xdma_vin_mem_clear_i(xdma_vin_mem_clear_i),
        .tx_start_i          (tx_start_i),
        .tx_frame_len_i      (tx_frame_len_i),
        .ddr_rd_req_o        (ddr_rd_req_o),
        .ddr_rd_valid_i      (ddr_rd_valid_i),
        .ddr_rd_data_i       (ddr_rd_data_i),
        .aurora_tx_tvalid_o  (aurora_tx_tvalid_o),
        .aurora_tx_tready_i  (aurora_tx_tready_i),
        .aurora_tx_tdata_o   (aurora_tx_tdata_o),
        .aurora_tx_tlast_o   (aurora_tx_tlast_o),
        .tx_busy_o           (tx_busy_o),
        .tx_beat_cnt_o       (tx_beat_cnt_o),
        .tx_stall_cnt_o      (tx_stall_cnt_o)
    );

    typedef struct {
        int            due;
        logic [IW-1:0] data;
    } rsp_t;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;

    rsp_t          pend_q[$];
    logic [IW-1:0] word_q[$];
    beat_t         exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_total = 0;
    int          beats_seen = 0;
    int          acc_cyc[8192];
    logic [31:0] model_beats = 0;
    logic [63:0] last_acc_data = 0;
    int          lat_base = 3;
    int          slow_idx = -1;
    int          slow_lat = 20;
    int          req_idx = 0;
    int          last_due = 0;
    bit          lat_rand = 0;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // DDR responder and sink-ready driver
    initial begin
        ddr_rd_valid_i     = 1'b0;
        ddr_rd_data_i      = '0;
        aurora_tx_tready_i = 1'b1;
        forever begin
            @(posedge aurora_log_clk_0);
            #1;
            cyc++;
            ddr_rd_valid_i = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                ddr_rd_valid_i = 1'b1;
                ddr_rd_data_i  = pend_q[0].data;
                void'(pend_q.pop_front());
            end
            case (rdy_mode)
                0:       aurora_tx_tready_i = 1'b1;
                1:       aurora_tx_tready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: aurora_tx_tready_i = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: scoreboard and per-cycle rules
    initial begin : mon
        bit          pstall;
        bit          pflush;
        bit          plast;
        bit          flush;
        logic [63:0] pd;
        logic        pl;
        beat_t       e;
        rsp_t        r;
        int          lat;
        pstall = 0;
        pflush = 0;
        plast  = 0;
        forever begin
            @(negedge aurora_log_clk_0);
            flush = aurora_rst_0 || xdma_vin_mem_clear_i;
            chk("beat_cnt", 64'(tx_beat_cnt_o), 64'(model_beats));
            if (pstall && !pflush) begin
                chk("hold_valid", 64'(aurora_tx_tvalid_o), 64'd1);
                chk("hold_data", aurora_tx_tdata_o, pd);
                chk("hold_last", 64'(aurora_tx_tlast_o), 64'(pl));
            end
            if (plast) chk("busy_after_last", 64'(tx_busy_o), 64'd0);
            checks++;
            if (pend_q.size() > 2) begin
                errors++;
                $display("FAIL ddr_inflight got=%0d want<=2", pend_q.size());
            end
            if (ddr_rd_req_o) begin
                req_total++;
                if (word_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_req got=1 want=0");
                end else begin
                    if (lat_rand) lat = $urandom_range(7, 1);
                    else if (req_idx == slow_idx) lat = slow_lat;
                    else lat = lat_base;
                    req_idx++;
                    r.due = cyc + lat;
                    if (r.due <= last_due) r.due = last_due + 1;
                    last_due = r.due;
                    r.data = word_q.pop_front();
                    pend_q.push_back(r);
                end
            end
            plast = 0;
            if (aurora_tx_tvalid_o && aurora_tx_tready_i && !flush) begin
                acc_cyc[beats_seen % 8192] = cyc;
                beats_seen++;
                model_beats = model_beats + 32'd1;
                last_acc_data = aurora_tx_tdata_o;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat got=%0h want=none", aurora_tx_tdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", aurora_tx_tdata_o, e.d);
                    chk("tlast", 64'(aurora_tx_tlast_o), 64'(e.l));
                    plast = e.l;
                end
            end
            pstall = aurora_tx_tvalid_o && !aurora_tx_tready_i;
            pd     = aurora_tx_tdata_o;
            pl     = aurora_tx_tlast_o;
            pflush = flush;
            if (flush) model_beats = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aurora_log_clk_0);
            #1;
        end
    endtask

    task automatic pulse_start(input int len);
        tick(1);
        tx_frame_len_i = LW'(len);
        tx_start_i     = 1'b1;
        tick(1);
        tx_start_i = 1'b0;
    endtask

    task automatic start_frame(input int len, input int base, input bit rnd);
        logic [IW-1:0] w;
        logic [63:0]   lane;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 8; k++) begin
                lane = rnd ? {$urandom, $urandom} : 64'(base + i * 8 + k);
                w[k*64 +: 64] = lane;
                exp_q.push_back('{lane, (i == len - 1) && (k == 7)});
            end
            word_q.push_back(w);
        end
        req_idx = 0;
        pulse_start(len);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((tx_busy_o || exp_q.size() != 0) && n < 3000) begin
            tick(1);
            n++;
        end
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout got=busy want=idle", name);
        end
    endtask

    task automatic wait_ddr_quiet();
        int n;
        n = 0;
        while (pend_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        tick(3);
    endtask

    task automatic mid_frame_abort(input bit use_rst);
        int s;
        int n;
        s = beats_seen;
        slow_idx = 1;
        start_frame(4, 1, 0);
        n = 0;
        while (beats_seen < s + 5 && n < 200) begin
            tick(1);
            n++;
        end
        if (use_rst) aurora_rst_0 = 1'b1;
        else xdma_vin_mem_clear_i = 1'b1;
        tick(1);
        aurora_rst_0         = 1'b0;
        xdma_vin_mem_clear_i = 1'b0;
        exp_q.delete();
        word_q.delete();
        slow_idx = -1;
        chk("abort_pending", 64'(pend_q.size()), 64'd1);
        chk("abort_tvalid", 64'(aurora_tx_tvalid_o), 64'd0);
        chk("abort_busy", 64'(tx_busy_o), 64'd0);
        chk("abort_beat_cnt", 64'(tx_beat_cnt_o), 64'd0);
        chk("abort_stall_cnt", 64'(tx_stall_cnt_o), 64'd0);
        wait_ddr_quiet();
        chk("late_rsp_tvalid", 64'(aurora_tx_tvalid_o), 64'd0);
        s = req_total;
        start_frame(1, 1, 0);
        wait_done("after_abort");
        chk("after_abort_reqs", 64'(req_total - s), 64'd1);
        chk("after_abort_beats", 64'(tx_beat_cnt_o), 64'd8);
        chk("after_abort_last", last_acc_data, 64'd8);
    endtask

    initial begin
        int s;
        int r0;
        aurora_rst_0         = 1'b1;
        xdma_vin_mem_clear_i = 1'b0;
        tx_start_i           = 1'b0;
        tx_frame_len_i       = '0;
        tick(2);
        chk("rst_busy", 64'(tx_busy_o), 64'd0);
        chk("rst_tvalid", 64'(aurora_tx_tvalid_o), 64'd0);
        chk("rst_req", 64'(ddr_rd_req_o), 64'd0);
        chk("rst_tdata", aurora_tx_tdata_o, 64'd0);
        chk("rst_tlast", 64'(aurora_tx_tlast_o), 64'd0);
        chk("rst_stall", 64'(tx_stall_cnt_o), 64'd0);
        aurora_rst_0 = 1'b0;
        tick(2);

        r0 = req_total;
        start_frame(1, 1, 0);
        wait_done("single");
        chk("single_reqs", 64'(req_total - r0), 64'd1);
        chk("single_beats", 64'(tx_beat_cnt_o), 64'd8);
        chk("single_stall", 64'(tx_stall_cnt_o), 64'd0);
        chk("single_last", last_acc_data, 64'd8);

        r0 = req_total;
        s  = beats_seen;
        start_frame(4, 1, 0);
        wait_done("stream");
        chk("stream_reqs", 64'(req_total - r0), 64'd4);
        chk("stream_span", 64'(acc_cyc[(s + 31) % 8192] - acc_cyc[s % 8192]), 64'd31);
        chk("stream_beats", 64'(tx_beat_cnt_o), 64'd40);
        chk("stream_stall", 64'(tx_stall_cnt_o), 64'd0);
        chk("stream_last", last_acc_data, 64'd32);

        r0 = req_total;
        rdy_mode = 1;
        start_frame(2, 1, 0);
        wait_done("backpressure");
        rdy_mode = 0;
        chk("bp_reqs", 64'(req_total - r0), 64'd2);
        chk("bp_beats", 64'(tx_beat_cnt_o), 64'd56);
        chk("bp_last", last_acc_data, 64'd16);
        chk("bp_stall", 64'(tx_stall_cnt_o), 64'd0);

        s = beats_seen;
        slow_idx = 1;
        start_frame(2, 1, 0);
        wait_done("starve");
        slow_idx = -1;
        chk("starve_stall", 64'(tx_stall_cnt_o), 64'd11);
        chk("starve_gap", 64'(acc_cyc[(s + 8) % 8192] - acc_cyc[(s + 7) % 8192]), 64'd12);
        chk("starve_beats", 64'(tx_beat_cnt_o), 64'd72);

        r0 = req_total;
        pulse_start(0);
        for (int i = 0; i < 5; i++) begin
            chk("len0_busy", 64'(tx_busy_o), 64'd0);
            tick(1);
        end
        chk("len0_reqs", 64'(req_total - r0), 64'd0);

        r0 = req_total;
        start_frame(2, 1, 0);
        tick(4);
        pulse_start(3);
        wait_done("midstart");
        chk("midstart_reqs", 64'(req_total - r0), 64'd2);
        chk("midstart_beats", 64'(tx_beat_cnt_o), 64'd88);
        chk("midstart_last", last_acc_data, 64'd16);

        mid_frame_abort(1'b0);
        mid_frame_abort(1'b1);

        rdy_mode = 2;
        lat_rand = 1;
        for (int f = 0; f < 10; f++) begin
            int len;
            len = $urandom_range(6, 1);
            r0 = req_total;
            start_frame(len, 0, 1);
            wait_done("random");
            chk("random_reqs", 64'(req_total - r0), 64'(len));
        end
        chk("random_stall", 64'(tx_stall_cnt_o), 64'd0);
        rdy_mode = 0;
        lat_rand = 0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aurora_tx_data_unpack.md
Name: aurora_tx_data_unpack

Overview:
- Reader-side counterpart of the Aurora RX → DDR packing path.
- Fetches 512-bit words from the DDR read interface, one request per word.
- Unpacks each word into eight 64-bit beats on an AXI-stream-style Aurora TX interface, with frame length control and status counters.
- Sits between the DDR read-data FIFO and the Aurora TX user interface in the aurora_log_clk_0 domain.

Parameters:
- IN_WIDTH, 512, DDR word width; must equal 8*OUT_WIDTH.
- OUT_WIDTH, 64, Aurora TX beat width.
- LEN_W, 16, width of the frame length field (in 512-bit words).

Ports:
- aurora_log_clk_0  in  1  logic clock; all logic is on its rising edge.
- aurora_rst_0  in  1  synchronous, active-high reset.
- xdma_vin_mem_clear_i  in  1  synchronous flush; aborts the frame and clears counters.
- tx_start_i  in  1  single-cycle frame start; sampled in IDLE only.
- tx_frame_len_i  in  LEN_W  frame length in 512-bit words; latched with tx_start_i.
- ddr_rd_req_o  out  1  one-cycle pulse; requests one 512-bit word.
- ddr_rd_valid_i  in  1  read data valid; exactly one pulse per request, latency ≥1 cycle.
- ddr_rd_data_i  in  IN_WIDTH  read data.
- aurora_tx_tvalid_o  out  1  beat valid.
- aurora_tx_tready_i  in  1  sink ready.
- aurora_tx_tdata_o  out  OUT_WIDTH  beat data.
- aurora_tx_tlast_o  out  1  last beat of frame.
- tx_busy_o  out  1  high whenever state ≠ IDLE.
- tx_beat_cnt_o  out  32  accepted beats since reset/clear.
- tx_stall_cnt_o  out  32  starvation cycles (see below).

Behaviour:
- Reset (aurora_rst_0=1 at a clock edge):
  - State → IDLE; buffer emptied.
  - All outputs 0, including both counters.
  - Reset mid-frame drops all buffered data; a DDR response arriving after reset is ignored.
- Buffer:
  - Two 512-bit entries: the active word and one prefetch word.
  - Lane order: bits [63:0] are sent first, [511:448] last.
  - The active word shifts right by 64 on each accepted beat.
- States:
  - IDLE: on tx_start_i=1 with tx_frame_len_i≠0, latch the length into req_left and beat_left (=len*8), then go to RUN. tx_start_i with len=0 is ignored and the state stays IDLE.
  - RUN:
    - Issue ddr_rd_req_o when req_left>0, outstanding requests + occupied entries < 2, and no request was issued in the previous cycle.
    - Each request decrements req_left.
    - The first request is issued in the cycle after tx_start_i.
    - RUN → IDLE on the cycle after the tlast beat is accepted.
  - tx_start_i while not IDLE is ignored.
- Data path:
  - ddr_rd_valid_i writes ddr_rd_data_i into the active entry if it is empty, otherwise into the prefetch entry.
  - ddr_rd_valid_i with no outstanding request is ignored.
  - tvalid is registered; it rises the cycle after data lands in an empty active entry.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - A beat is accepted when tvalid & tready.
  - After the 8th beat of a word, the prefetch entry moves to active in the same cycle. Back-to-back streaming at one beat per cycle is sustained if the DDR latency is ≤7 cycles.
  - tlast=1 only on the beat where beat_left==1.
- Counters:
  - tx_beat_cnt_o increments on each accepted beat.
  - tx_stall_cnt_o increments each RUN cycle with tvalid=0 after the first beat of the frame was accepted, i.e. DDR starvation.
  - Both counters wrap at 2^32.
  - Both are cleared by xdma_vin_mem_clear_i.
- xdma_vin_mem_clear_i:
  - Same effect as reset, except it takes priority over a simultaneous beat acceptance or DDR write.
  - Outstanding DDR responses after the clear are discarded: an outstanding counter tracks them and discards them on return.
- Simultaneous events:
  - Accepting the last beat of the active word while ddr_rd_valid_i arrives with the prefetch entry empty: the new data goes directly to the active entry with no bubble.
  - An unsolicited ddr_rd_valid_i in IDLE is ignored.

Test Plan:
- Single word:
  - Stimulus: len=1; DDR returns 0x…0008_…_0002_0001 (lane k = k+1) with 3-cycle latency; tready=1.
  - Expected: exactly one req pulse; 8 beats with tdata 1..8; tlast only on 8; tx_beat_cnt_o=8; tx_stall_cnt_o=0; busy falls the cycle after beat 8.
- Streaming:
  - Stimulus: len=4 with incrementing lanes 1..32; latency 3; tready=1.
  - Expected: 32 consecutive beats with no tvalid gaps; exactly 4 req pulses; never more than 2 outstanding+buffered; tlast on beat 32.
- Backpressure:
  - Stimulus: len=2; tready toggles 1,0,0,1 repeatedly.
  - Expected: tdata/tlast held stable while stalled; beats 1..16 delivered in order; beat count=16.
- Starvation:
  - Stimulus: len=2; second word returned with 20-cycle latency.
  - Expected: tvalid gap after beat 8; tx_stall_cnt_o counts the gap cycles; stream resumes with beat 9 in the correct order.
- Flush and reset mid-frame:
  - Stimulus: len=4; assert xdma_vin_mem_clear_i after beat 5, with one DDR response still pending.
  - Expected: tvalid=0 next cycle; IDLE; counters=0; the late response is discarded; a following len=1 frame outputs correct beats 1..8.
  - Repeat with aurora_rst_0 in place of the clear: same result.
- Ignored starts:
  - Stimulus: tx_start_i with len=0; tx_start_i asserted mid-frame.
  - Expected: no req pulses or state change for len=0; the running frame completes unchanged.
